dmem_io_mmap: RTL and testbench

//  Parametrised data memory with memory-mapped IO for the PMIPS pipelined CPU; successor of the fixed
//  2-switch/1-digit data-memory/IO device. Adds word RAM of DEPTH words, NUM_SW synchronised and

---
 rtl/dmem_io_mmap.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_io_mmap.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_io_mmap.sv
// dmem_io_mmap: data memory with memory-mapped IO for the PMIPS pipelined CPU.
// Provides word RAM, debounced switches with sticky rising-edge flags, and a
// multiplexed hex 7-segment display, all on the CPU data-memory port.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   dmemaddr     byte address (bit 0 ignored, word access)
//   dmemwdata    write data
//   dmemwrite    write enable, sampled at the rising edge
//   dmemread     read enable (combinational read path)
//   io_sw        raw asynchronous switch levels
//   dmemrdata    read data, 0 when dmemread is low or address unmapped
//   io_display   segments {g,f,e,d,c,b,a}, active-high
//   io_digit_en  one-hot digit enable, active-high
//   addr_err     one-cycle pulse after an access to an unmapped address
//
// Map: 0x0000..2*DEPTH-1 RAM, 0xFFF0 DISP (rw), 0xFFF2 SW (ro),
//      0xFFF4 EDGE (write-1-to-clear).

module dmem_io_mmap #(
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned NUM_SW     = 2,
  parameter int unsigned NUM_DIGITS = 1,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned SCAN       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [15:0]           dmemaddr,
  input  logic [15:0]           dmemwdata,
  input  logic                  dmemwrite,
  input  logic                  dmemread,
  input  logic [NUM_SW-1:0]     io_sw,
  output logic [15:0]           dmemrdata,
  output logic [6:0]            io_display,
  output logic [NUM_DIGITS-1:0] io_digit_en,
  output logic                  addr_err
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEBOUNCE) + 1;
  localparam int unsigned DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SCW = (SCAN > 1) ? $clog2(SCAN) : 1;

  // Word addresses (byte address >> 1) of the IO registers.
  localparam logic [14:0] DispWord = 15'h7FF8;
  localparam logic [14:0] SwWord   = 15'h7FF9;
  localparam logic [14:0] EdgeWord = 15'h7FFA;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          ram_hit, disp_hit, sw_hit, edge_hit, mapped;
  logic [AW-1:0] ram_idx;

  assign ram_idx  = dmemaddr[AW:1];
  assign ram_hit  = (dmemaddr[15:AW+1] == '0);
  assign disp_hit = (dmemaddr[15:1] == DispWord);
  assign sw_hit   = (dmemaddr[15:1] == SwWord);
  assign edge_hit = (dmemaddr[15:1] == EdgeWord);
  assign mapped   = ram_hit | disp_hit | sw_hit | edge_hit;

  // ---------------------------------------------------------------------------
  // RAM: contents deliberately survive reset
  // ---------------------------------------------------------------------------
  logic [15:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (dmemwrite && ram_hit) begin
      mem[ram_idx] <= dmemwdata;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0]                 disp_q, disp_d;
  logic [NUM_SW-1:0]           s1_q, s2_q;
  logic [NUM_SW-1:0]           stable_q, stable_d;
  logic [NUM_SW-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [NUM_SW-1:0]           edge_q, edge_d;
  logic [NUM_SW-1:0]           edge_clr;
  logic [DW-1:0]               dig_q, dig_d;
  logic [SCW-1:0]              sc_q, sc_d;
  logic                        addr_err_q, addr_err_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_q     <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      edge_q     <= '0;
      dig_q      <= '0;
      sc_q       <= '0;
      addr_err_q <= 1'b0;
    end else begin
      disp_q     <= disp_d;
      s1_q       <= io_sw;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      dig_q      <= dig_d;
      sc_q       <= sc_d;
      addr_err_q <= addr_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register writes and error flag
  // ---------------------------------------------------------------------------
  always_comb begin
    disp_d   = disp_q;
    edge_clr = '0;
    if (dmemwrite && disp_hit) begin
      disp_d = dmemwdata;
    end
    if (dmemwrite && edge_hit) begin
      edge_clr = dmemwdata[NUM_SW-1:0];
    end
    addr_err_d = (dmemread | dmemwrite) & ~mapped;
  end

  // ---------------------------------------------------------------------------
  // Debounce: a synchronised level must differ from stable for DEBOUNCE
  // consecutive cycles; any return to the stable level restarts the count.
  // ---------------------------------------------------------------------------
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NUM_SW; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    // A new rising edge overrides a simultaneous write-1-to-clear.
    edge_d = (edge_q & ~edge_clr) | (stable_d & ~stable_q);
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  always_comb begin
    sc_d  = sc_q + SCW'(1);
    dig_d = dig_q;
    if (sc_q == SCW'(SCAN - 1)) begin
      sc_d = '0;
      if (dig_q == DW'(NUM_DIGITS - 1)) begin
        dig_d = '0;
      end else begin
        dig_d = dig_q + DW'(1);
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [3:0] nib;

  always_comb begin
    nib = disp_q[3:0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_q == DW'(i)) begin
        nib = disp_q[4*i +: 4];
      end
    end
  end

  assign io_display  = hex7(nib);
  assign io_digit_en = NUM_DIGITS'(1) << dig_q;
  assign addr_err    = addr_err_q;

  // ---------------------------------------------------------------------------
  // Combinational read: reflects state before any write landing this edge
  // ---------------------------------------------------------------------------
  always_comb begin
    dmemrdata = '0;
    if (dmemread) begin
      if (ram_hit) begin
        dmemrdata = mem[ram_idx];
      end else if (disp_hit) begin
        dmemrdata = disp_q;
      end else if (sw_hit) begin
        dmemrdata[NUM_SW-1:0] = stable_q;
      end else if (edge_hit) begin
        dmemrdata[NUM_SW-1:0] = edge_q;
      end
    end
  end

endmodule

// File: tb/tb_dmem_io_mmap.sv
// Bench for dmem_io_mmap: scoreboard of expected read data plus a per-cycle
// check of addr_err and the display against a window-based reference model.
module tb_dmem_io_mmap;

  localparam int unsigned DEPTH      = 128;
  localparam int unsigned NUM_SW     = 2;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DEBOUNCE   = 4;
  localparam int unsigned SCAN       = 2;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [15:0]           dmemaddr = '0;
  logic [15:0]           dmemwdata = '0;
  logic                  dmemwrite = 1'b0;
  logic                  dmemread = 1'b0;
  logic [NUM_SW-1:0]     io_sw = '0;
  logic [15:0]           dmemrdata;
  logic [6:0]            io_display;
  logic [NUM_DIGITS-1:0] io_digit_en;
  logic                  addr_err;

  dmem_io_mmap #(
    .DEPTH      (DEPTH),
    .NUM_SW     (NUM_SW),
    .NUM_DIGITS (NUM_DIGITS),
    .DEBOUNCE   (DEBOUNCE),
    .SCAN       (SCAN)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .dmemaddr    (dmemaddr),
    .dmemwdata   (dmemwdata),
    .dmemwrite   (dmemwrite),
    .dmemread    (dmemread),
    .io_sw       (io_sw),
    .dmemrdata   (dmemrdata),
    .io_display  (io_display),
    .io_digit_en (io_digit_en),
    .addr_err    (addr_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0]       m_mem [DEPTH];
  logic [15:0]       m_disp;
  logic [NUM_SW-1:0] m_stable;
  logic [NUM_SW-1:0] m_edge;
  logic              m_err;
  int                m_t;
  logic [NUM_SW-1:0] hist [$];   // raw switch level sampled at each edge
  logic [15:0]       rd_q [$];   // scoreboard of expected read data
  logic [NUM_SW-1:0] sw_cur;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_ram(input logic [15:0] a);
    return 32'(a) < 2 * DEPTH;
  endfunction

  function automatic bit is_reg(input logic [15:0] a, input logic [15:0] base);
    return (a & 16'hFFFE) == base;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (is_ram(a)) return m_mem[int'(a >> 1)];
    if (is_reg(a, 16'hFFF0)) return m_disp;
    if (is_reg(a, 16'hFFF2)) return 16'(m_stable);
    if (is_reg(a, 16'hFFF4)) return 16'(m_edge);
    return 16'h0;
  endfunction

  task automatic model_reset();
    m_disp   = '0;
    m_stable = '0;
    m_edge   = '0;
    m_err    = 1'b0;
    m_t      = 0;
    hist.delete();
    for (int k = 0; k < int'(DEBOUNCE) + 2; k++) hist.push_back('0);
  endtask

  // Effect of one rising edge. A switch bit takes a new level at edge m when
  // the raw samples taken at edges m-1-DEBOUNCE .. m-2 all carry that level.
  task automatic model_edge(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [15:0] wd, input logic [NUM_SW-1:0] sw);
    logic [NUM_SW-1:0] old;
    logic [NUM_SW-1:0] clr;
    bit                all;
    old   = m_stable;
    clr   = '0;
    m_err = (rd | wr) && !(is_ram(a) || is_reg(a, 16'hFFF0) || is_reg(a, 16'hFFF2) ||
                           is_reg(a, 16'hFFF4));
    if (wr) begin
      if (is_ram(a)) m_mem[int'(a >> 1)] = wd;
      else if (is_reg(a, 16'hFFF0)) m_disp = wd;
      else if (is_reg(a, 16'hFFF4)) clr = wd[NUM_SW-1:0];
    end
    hist.push_back(sw);
    while (hist.size() > DEBOUNCE + 2) void'(hist.pop_front());
    for (int i = 0; i < NUM_SW; i++) begin
      all = 1;
      for (int k = 3; k <= int'(DEBOUNCE) + 2; k++) begin
        if (hist[hist.size() - k][i] == old[i]) all = 0;
      end
      if (all) m_stable[i] = ~old[i];
    end
    m_edge = (m_edge & ~clr) | (m_stable & ~old);
    m_t++;
  endtask

  // One bus cycle: drive, queue the expected read, let the edge land.
  task automatic cycle(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic [NUM_SW-1:0] sw);
    dmemread  = rd;
    dmemwrite = wr;
    dmemaddr  = a;
    dmemwdata = wd;
    io_sw     = sw;
    sw_cur    = sw;
    if (rd) rd_q.push_back(model_read(a));
    @(posedge clock);
    model_edge(rd, wr, a, wd, sw);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 16'h0, 16'h0, sw_cur);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_display"}, 16'(io_display), 16'h3F);
    check({tag, "_digit_en"}, 16'(io_digit_en), 16'h1);
    check({tag, "_addr_err"}, 16'(addr_err), 16'h0);
    dmemread = 1'b1;
    dmemaddr = 16'hFFF2;
    #1 check({tag, "_sw"}, dmemrdata, 16'h0);
    dmemaddr = 16'hFFF4;
    #1 check({tag, "_edge"}, dmemrdata, 16'h0);
    dmemaddr = 16'hFFF0;
    #1 check({tag, "_disp"}, dmemrdata, 16'h0);
    dmemread = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against model/scoreboard.
  always @(negedge clock) begin
    int          d;
    logic [3:0]  nib;
    if (reset) begin
      if (dmemread) begin
        if (rd_q.size() == 0) check("rd_underflow", 16'h1, 16'h0);
        else check("rdata", dmemrdata, rd_q.pop_front());
      end else begin
        check("rdata_idle", dmemrdata, 16'h0);
      end
      d   = (m_t / int'(SCAN)) % int'(NUM_DIGITS);
      nib = 4'(m_disp >> (4 * d));
      check("addr_err", 16'(addr_err), 16'(m_err));
      check("digit_en", 16'(io_digit_en), 16'(1 << d));
      check("display", 16'(io_display), 16'(HEX[nib]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] a, wd;
    logic        rd, wr;
    int          op;

    sw_cur = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset_checks("t1_reset");
    reset = 1'b1;

    // Fill RAM so every later read has a defined expectation.
    for (int w = 0; w < int'(DEPTH); w++) cycle(1'b0, 1'b1, 16'(2 * w), 16'($urandom), '0);
    cycle(1'b0, 1'b1, 16'h0004, 16'hBEEF, '0);
    cycle(1'b1, 1'b0, 16'h0004, 16'h0, '0);

    // T2: debounce latency, edge flag, W1C, short glitch rejected.
    idle(3);
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 16'hFFF2, 16'h0, 2'b01);
    cycle(1'b1, 1'b0, 16'hFFF4, 16'h0, 2'b01);
    cycle(1'b0, 1'b1, 16'hFFF4, 16'h0001, 2'b01);
    cycle(1'b1, 1'b0, 16'hFFF4, 16'h0, 2'b01);
    cycle(1'b1, 1'b0, 16'hFFF2, 16'h0, 2'b11);
    cycle(1'b1, 1'b0, 16'hFFF2, 16'h0, 2'b11);
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, (k % 2) ? 16'hFFF4 : 16'hFFF2, 16'h0, 2'b01);

    // T3: W1C on the very edge stable[0] rises.
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 16'hFFF2, 16'h0, 2'b00);
    cycle(1'b0, 1'b1, 16'hFFF4, 16'h0003, 2'b00);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 2'b01);
    idle(4);
    cycle(1'b0, 1'b1, 16'hFFF4, 16'h0001, 2'b01);
    cycle(1'b1, 1'b0, 16'hFFF4, 16'h0, 2'b01);

    // T4: multiplexed scan of 1A2F.
    cycle(1'b0, 1'b1, 16'hFFF0, 16'h1A2F, 2'b01);
    idle(12);
    cycle(1'b1, 1'b0, 16'hFFF0, 16'h0, 2'b01);

    // T5: unmapped read and write, then confirm nothing moved.
    cycle(1'b1, 1'b0, 16'h8000, 16'h0, 2'b01);
    cycle(1'b0, 1'b1, 16'hFFFE, 16'h5555, 2'b01);
    cycle(1'b1, 1'b0, 16'hFFF0, 16'h0, 2'b01);
    cycle(1'b1, 1'b1, 16'h0004, 16'h1234, 2'b01);
    cycle(1'b1, 1'b0, 16'h0005, 16'h0, 2'b01);

    // Randomised traffic with random switch activity.
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 7));
      wd = 16'($urandom);
      rd = 1'b0;
      wr = 1'b0;
      a  = 16'($urandom_range(0, 2 * DEPTH - 1));
      case (op)
        0, 1: rd = 1'b1;
        2:    wr = 1'b1;
        3:    begin a = 16'hFFF0 | 16'($urandom_range(0, 1)); rd = 1'($urandom); wr = ~rd; end
        4:    begin a = 16'hFFF2 | 16'($urandom_range(0, 1)); rd = 1'($urandom); wr = ~rd; end
        5:    begin a = 16'hFFF4; rd = 1'($urandom); wr = 1'($urandom); end
        6:    begin a = 16'($urandom); rd = 1'($urandom); wr = 1'($urandom); end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      if ($urandom_range(0, 9) == 0) sw_cur = NUM_SW'($urandom);
      cycle(rd, wr, a, wd, sw_cur);
    end

    // T6: reset mid-scan and mid-debounce; RAM survives.
    cycle(1'b0, 1'b1, 16'h0004, 16'hBEEF, sw_cur);
    cycle(1'b0, 1'b1, 16'hFFF0, 16'hC3D7, sw_cur);
    idle(10);
    sw_cur = ~sw_cur;
    idle(2);
    @(negedge clock);
    #1 reset = 1'b0;
    #1 reset_checks("t6_reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0, 16'h0004, 16'h0, sw_cur);
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, (k % 2) ? 16'hFFF4 : 16'hFFF2, 16'h0, sw_cur);

    idle(2);
    check("scoreboard_drained", 16'(rd_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
